// File: rtl/seven_seg_pkg.sv
// Shared constants and types for the multiplexed seven-segment scanner.
// Segment patterns are active-high gfedcba; the board pins are active-low.
package seven_seg_pkg;

    localparam logic [7:0] SEG_OFF = 8'hFF;
    localparam logic [3:0] AN_OFF  = 4'hF;

    localparam logic [6:0] HEX_SEG [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F,
        7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C,
        7'h39, 7'h5E, 7'h79, 7'h71
    };

    typedef enum logic {
        PH_BLANK = 1'b0,
        PH_DRIVE = 1'b1
    } phase_e;

    typedef struct packed {
        logic [15:0] value;
        logic [3:0]  dp;
        logic [3:0]  en;
    } disp_t;

endpackage

// File: rtl/seven_seg_decode.sv
// Hex nibble plus decimal point to active-low {dp,g,f,e,d,c,b,a}.
module seven_seg_decode
    import seven_seg_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       dp,
    output logic [7:0] seg_c
);

    assign seg_c = {~dp, ~HEX_SEG[nibble]};

endmodule

// File: rtl/seven_seg_scan.sv
// Four-digit seven-segment scanner with per-slot blanking and tear-free,
// frame-aligned display updates. Define SEVEN_SEG_LZB_EN for leading-zero blanking.
module seven_seg_scan
    import seven_seg_pkg::*;
#(
    parameter int unsigned REFRESH_DIV  = 100000,
    parameter int unsigned BLANK_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] value,
    input  logic [3:0]  dp_in,
    input  logic [3:0]  digit_en,
    input  logic        load,
    output logic [7:0]  seg,
    output logic [3:0]  an,
    output logic        frame
);

    localparam int unsigned       CNT_W   = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(REFRESH_DIV - 1);

    logic [CNT_W-1:0] div_cnt;
    logic [1:0]       idx;
    disp_t            disp;
    disp_t            pend;
    logic             pend_valid;

    logic             slot_end;
    logic             boundary;
    phase_e           phase;
    disp_t            load_data;
    logic [3:0]       sup;
    logic [3:0]       cur_nib;
    logic [7:0]       dec_seg_c;
    logic [7:0]       seg_c;
    logic [3:0]       an_c;

    assign slot_end  = (div_cnt == CNT_MAX);
    assign boundary  = slot_end && (idx == 2'd3);
    assign load_data = '{value: value, dp: dp_in, en: digit_en};

    always_comb begin
        phase = PH_DRIVE;
        if (32'(div_cnt) < BLANK_CYCLES) phase = PH_BLANK;
    end

    // Slot counter and digit index
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
            idx     <= 2'd0;
        end else if (slot_end) begin
            div_cnt <= '0;
            idx     <= idx + 2'd1;
        end else begin
            div_cnt <= div_cnt + CNT_W'(1);
        end
    end

    // Pending/display registers; display only moves at the frame boundary
    always_ff @(posedge clk) begin
        if (rst) begin
            disp       <= '0;
            pend       <= '0;
            pend_valid <= 1'b0;
        end else if (boundary) begin
            if (load) begin
                disp <= load_data;
            end else if (pend_valid) begin
                disp <= pend;
            end
            pend_valid <= 1'b0;
        end else if (load) begin
            pend       <= load_data;
            pend_valid <= 1'b1;
        end
    end

`ifdef SEVEN_SEG_LZB_EN
    // A digit is dropped only when it and every higher shown digit are blank zeros
    always_comb begin
        logic hi_blank;
        sup      = 4'b0000;
        hi_blank = 1'b1;
        for (int k = 3; k >= 1; k--) begin
            sup[k]   = hi_blank && (disp.value[4*k +: 4] == 4'h0) && !disp.dp[k];
            hi_blank = hi_blank && (!disp.en[k] || sup[k]);
        end
    end
`else
    assign sup = 4'b0000;
`endif

    assign cur_nib = 4'(disp.value >> {idx, 2'b00});

    seven_seg_decode u_decode (
        .nibble (cur_nib),
        .dp     (disp.dp[idx]),
        .seg_c  (dec_seg_c)
    );

    always_comb begin
        an_c  = AN_OFF;
        seg_c = SEG_OFF;
        if (phase == PH_DRIVE && disp.en[idx] && !sup[idx]) begin
            an_c  = ~(4'b0001 << idx);
            seg_c = dec_seg_c;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seg   <= SEG_OFF;
            an    <= AN_OFF;
            frame <= 1'b0;
        end else begin
            seg   <= seg_c;
            an    <= an_c;
            frame <= boundary;
        end
    end

endmodule
